// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register and a req/ack port to instruction memory.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
//
// state  | meaning
// S_IDLE | out of reset, no request yet issued
// S_WAIT | request outstanding at imem_addr, waiting for imem_ack
// S_HELD | word returned during a stall, parked in the skid buffer
module fetch_stage #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ack,
  output logic                if_id_valid,
  output logic [5:0]          instr_op,
  output logic [4:0]          instr_rs,
  output logic [4:0]          instr_rt,
  output logic [4:0]          instr_rd,
  output logic [15:0]         instr_imm,
  output logic [5:0]          instr_funct,
  output logic [PC_WIDTH-1:0] if_id_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HELD = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

  state_t              state;
  state_t              state_next;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] stale_addr;
  logic                discard;
  logic [31:0]         skid;
  logic [31:0]         ifid_word;

  logic                ack_accept;
  logic                take_fresh;
  logic                take_skid;
  logic                to_skid;
  logic                load_ifid;
  logic [31:0]         load_word;

  assign pc_plus4 = pc + PC_STEP;

  always_comb begin
    ack_accept = (state == S_WAIT) && imem_ack;
    take_fresh = ack_accept && !discard && !branch_taken && !stall;
    to_skid    = ack_accept && !discard && !branch_taken && stall;
    take_skid  = (state == S_HELD) && !stall && !branch_taken;
    load_ifid  = take_fresh || take_skid;
    load_word  = take_skid ? skid : imem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_WAIT;
      S_WAIT:  if (to_skid) state_next = S_HELD;
      S_HELD:  if (branch_taken || !stall) state_next = S_WAIT;
      default: state_next = S_IDLE;
    endcase
  end

  // While a redirected request is still in flight the bus keeps the old address.
  always_comb begin
    imem_req  = (state == S_WAIT);
    imem_addr = discard ? stale_addr : pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_PC & ALIGN_MASK;
      stale_addr     <= RESET_PC & ALIGN_MASK;
      discard        <= 1'b0;
      skid           <= 32'h0;
      ifid_word      <= 32'h0;
      if_id_valid    <= 1'b0;
      if_id_pc_plus4 <= '0;
    end else if (branch_taken) begin
      pc             <= branch_target & ALIGN_MASK;
      skid           <= 32'h0;
      ifid_word      <= 32'h0;
      if_id_valid    <= 1'b0;
      if_id_pc_plus4 <= '0;
      if ((state == S_WAIT) && !imem_ack) begin
        discard <= 1'b1;
        if (!discard) stale_addr <= pc;
      end else begin
        discard <= 1'b0;
      end
    end else begin
      if (ack_accept && discard) discard <= 1'b0;
      if (to_skid) skid <= imem_rdata;
      if (load_ifid) begin
        ifid_word      <= load_word;
        if_id_valid    <= 1'b1;
        if_id_pc_plus4 <= pc_plus4;
        pc             <= pc_plus4;
      end
    end
  end

  assign instr_op    = ifid_word[31:26];
  assign instr_rs    = ifid_word[25:21];
  assign instr_rt    = ifid_word[20:16];
  assign instr_rd    = ifid_word[15:11];
  assign instr_imm   = ifid_word[15:0];
  assign instr_funct = ifid_word[5:0];

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched      <= 32'h0;
      perf_stall_cycles <= 32'h0;
    end else begin
      if (load_ifid && (perf_fetched != 32'hFFFF_FFFF))
        perf_fetched <= perf_fetched + 32'd1;
      if (stall && if_id_valid && (perf_stall_cycles != 32'hFFFF_FFFF))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized checks of fetch_stage; the random phase compares against a
// program-order model: expected fetch address, memory image function and flush/hold rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, branch_taken, imem_ack;
  logic [31:0] branch_target, imem_rdata;

  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_pc_plus4;
  logic [5:0]  instr_op, instr_funct;
  logic [4:0]  instr_rs, instr_rt, instr_rd;
  logic [15:0] instr_imm;

  logic        b_req, b_valid;
  logic [31:0] b_addr, b_pp4;
  logic [5:0]  b_op, b_funct;
  logic [4:0]  b_rs, b_rt, b_rd;
  logic [15:0] b_imm;

  int total = 0;
  int bad   = 0;

  fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .if_id_valid(if_id_valid),
    .instr_op(instr_op), .instr_rs(instr_rs), .instr_rt(instr_rt), .instr_rd(instr_rd),
    .instr_imm(instr_imm), .instr_funct(instr_funct), .if_id_pc_plus4(if_id_pc_plus4)
  );

  // Second instance exercises PC wrap from the top of the address space.
  fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(b_req), .imem_addr(b_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .if_id_valid(b_valid),
    .instr_op(b_op), .instr_rs(b_rs), .instr_rt(b_rt), .instr_rd(b_rd),
    .instr_imm(b_imm), .instr_funct(b_funct), .if_id_pc_plus4(b_pp4)
  );

  logic [31:0] obs_word;
  assign obs_word = {instr_op, instr_rs, instr_rt, instr_imm};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] words [3];
    logic [5:0]  ops [3];
    logic [31:0] exp_pc, req_lat, exp_w, wrap_addr;
    logic [31:0] prev_word, prev_pp4;
    logic        prev_valid, stale, pending;
    int          delay, loads;

    words = '{32'h8C22_0004, 32'h0043_2020, 32'h1000_FFFE};
    ops   = '{6'h23, 6'h00, 6'h04};

    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    imem_rdata = 32'h0; imem_ack = 1'b0;
    tick(); tick();
    check("rst_req", 32'(imem_req), 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(if_id_valid), 0);
    check("rst_word", obs_word, 32'h0);
    check("rst_pp4", if_id_pc_plus4, 32'h0);
    check("rst_rd_funct", 32'({instr_rd, instr_funct}), 0);
    check("rst_wrap_addr", b_addr, 32'hFFFF_FFFC);

    rst = 1'b0;
    tick();
    check("first_req", 32'(imem_req), 1);
    check("first_addr", imem_addr, 32'h0);

    // back-to-back single-cycle acks
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1; imem_rdata = words[i];
      tick();
      wrap_addr = 32'hFFFF_FFFC + 32'(4 * (i + 1));
      check("stream_op", 32'(instr_op), 32'(ops[i]));
      check("stream_pp4", if_id_pc_plus4, 32'(4 * (i + 1)));
      check("stream_addr", imem_addr, 32'(4 * (i + 1)));
      check("stream_valid", 32'(if_id_valid), 1);
      check("wrap_addr", b_addr, wrap_addr);
      check("wrap_pp4", b_pp4, wrap_addr);
    end
    imem_ack = 1'b0;

    // ack delayed by three cycles
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int k = 0; k < 4; k++) begin
      check("delay_req", 32'(imem_req), 1);
      check("delay_addr", imem_addr, 32'h0);
      check("delay_valid", 32'(if_id_valid), 0);
      if (k < 3) tick();
    end
    imem_ack = 1'b1; imem_rdata = 32'hAC41_0008;
    tick();
    check("delay_load", obs_word, 32'hAC41_0008);
    check("delay_pp4", if_id_pc_plus4, 32'h4);

    // ack during a two-cycle stall goes to the skid buffer
    stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h8C62_0010;
    tick();
    check("stall_req0", 32'(imem_req), 0);
    check("stall_hold0", obs_word, 32'hAC41_0008);
    imem_ack = 1'b0; imem_rdata = 32'h0;
    tick();
    check("stall_req1", 32'(imem_req), 0);
    check("stall_hold1", obs_word, 32'hAC41_0008);
    check("stall_pp4", if_id_pc_plus4, 32'h4);
    stall = 1'b0;
    tick();
    check("skid_word", obs_word, 32'h8C62_0010);
    check("skid_pp4", if_id_pc_plus4, 32'h8);
    check("skid_req", 32'(imem_req), 1);
    check("skid_addr", imem_addr, 32'h8);

    // redirect while the request to 0x8 is outstanding
    branch_taken = 1'b1; branch_target = 32'h103;
    tick();
    branch_taken = 1'b0;
    check("br_valid", 32'(if_id_valid), 0);
    check("br_word", obs_word, 32'h0);
    check("br_old_addr", imem_addr, 32'h8);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    check("br_drop_valid", 32'(if_id_valid), 0);
    check("br_target_addr", imem_addr, 32'h100);
    imem_rdata = 32'h2042_0001;
    tick();
    check("br_load_word", obs_word, 32'h2042_0001);
    check("br_load_pp4", if_id_pc_plus4, 32'h104);

    // reset during S_WAIT with an ack in the same cycle
    rst = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    check("rst_ack_valid", 32'(if_id_valid), 0);
    check("rst_ack_word", obs_word, 32'h0);
    check("rst_ack_pp4", if_id_pc_plus4, 32'h0);
    check("rst_ack_req", 32'(imem_req), 0);
    check("rst_ack_addr", imem_addr, 32'h0);
    rst = 1'b0; imem_ack = 1'b0;
    tick();
    check("post_rst_addr", imem_addr, 32'h0);
    check("post_rst_valid", 32'(if_id_valid), 0);

    // randomized phase against the program-order model
    exp_pc = 32'h0; stale = 1'b0; pending = 1'b0; delay = 0; loads = 0; req_lat = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      branch_taken  = ($urandom_range(0, 19) == 0);
      branch_target = $urandom;
      if ($urandom_range(0, 3) == 0) stall = ~stall;
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (imem_req) begin
        if (!pending) begin
          pending = 1'b1;
          delay   = $urandom_range(0, 3);
          req_lat = imem_addr;
          check("rnd_req_addr", imem_addr, exp_pc);
        end else begin
          check("rnd_addr_stable", imem_addr, req_lat);
        end
        if (delay == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          pending    = 1'b0;
        end else begin
          delay--;
        end
      end
      if (imem_ack) stale = 1'b0;
      if (branch_taken && imem_req && !imem_ack) stale = 1'b1;
      prev_word = obs_word; prev_pp4 = if_id_pc_plus4; prev_valid = if_id_valid;

      tick();

      if (branch_taken) begin
        exp_pc = branch_target & ~32'h3;
        check("rnd_flush_valid", 32'(if_id_valid), 0);
        check("rnd_flush_word", obs_word, 32'h0);
      end else if (stall) begin
        check("rnd_hold_valid", 32'(if_id_valid), 32'(prev_valid));
        check("rnd_hold_word", obs_word, prev_word);
        check("rnd_hold_pp4", if_id_pc_plus4, prev_pp4);
      end else if (if_id_valid && (!prev_valid || (if_id_pc_plus4 != prev_pp4))) begin
        exp_w = mem_word(exp_pc);
        check("rnd_load_pp4", if_id_pc_plus4, exp_pc + 32'h4);
        check("rnd_load_word", obs_word, exp_w);
        check("rnd_load_rd", 32'(instr_rd), 32'(exp_w[15:11]));
        check("rnd_load_funct", 32'(instr_funct), 32'(exp_w[5:0]));
        exp_pc = exp_pc + 32'h4;
        loads++;
      end
    end
    check("rnd_loads_seen", 32'(loads > 100), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage plus IF/ID pipeline register; sits directly upstream of the decode control unit and drives its 6-bit opcode input.
- Owns the PC and runs a req/ack handshake to instruction memory.
- Handles stall from the hazard unit and flush/redirect on taken branch.
- Presents decoded instruction fields to decode and the register file.

Parameters:
- PC_WIDTH, 32, width of PC and memory address; PC increments wrap modulo 2^PC_WIDTH.
- RESET_PC, 0, PC value loaded on reset; low 2 bits must be 0.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold IF/ID contents and PC.
- branch_taken  input  1  redirect PC and flush IF/ID.
- branch_target  input  PC_WIDTH  redirect address; bits [1:0] forced to 0 internally.
- imem_req  output  1  fetch request.
- imem_addr  output  PC_WIDTH  fetch address; stable while imem_req=1 until imem_ack.
- imem_rdata  input  32  instruction word; valid only when imem_ack=1.
- imem_ack  input  1  one-cycle completion pulse; 0..N cycles after req.
- if_id_valid  output  1  IF/ID holds a real instruction.
- instr_op  output  6  instr[31:26], to control unit.
- instr_rs  output  5  instr[25:21].
- instr_rt  output  5  instr[20:16].
- instr_rd  output  5  instr[15:11].
- instr_imm  output  16  instr[15:0].
- instr_funct  output  6  instr[5:0].
- if_id_pc_plus4  output  PC_WIDTH  address of the latched instruction + 4.

Behaviour:
- Reset (rst=1 at edge, any state, including mid-request):
  - pc=RESET_PC, state=S_IDLE, imem_req=0, imem_addr=RESET_PC.
  - if_id_valid=0; all instr fields 0 (IF/ID word = 32'h0, the MIPS nop); if_id_pc_plus4=0.
  - discard flag cleared; skid buffer cleared.
  - An ack arriving in the reset cycle is ignored.
- State S_IDLE: next edge goes to S_WAIT with imem_req=1, imem_addr=pc.
- State S_WAIT:
  - imem_req held at 1; addr stable until ack.
  - On ack with stall=0 and discard=0: IF/ID <= imem_rdata, if_id_valid=1, if_id_pc_plus4=pc+4, pc<=pc+4. Remain in S_WAIT with the new address in the next cycle, giving one instruction per cycle when ack is combinational-fast.
  - On ack with stall=1: word goes to the skid buffer, imem_req drops, state goes to S_HELD; IF/ID unchanged.
- State S_HELD (imem_req=0): on the first cycle with stall=0, IF/ID <= skid, pc<=pc+4, state goes to S_WAIT.
- Stall with no ack: IF/ID and pc hold; an outstanding request stays outstanding.
- branch_taken (priority over stall, below rst):
  - pc<=branch_target & ~3; IF/ID word <= 32'h0; if_id_valid<=0; skid cleared.
  - In S_WAIT without ack in the same cycle: set discard. The old request continues until its ack, and that ack's data is dropped. Then clear discard and request the target.
  - In S_WAIT with ack in the same cycle: the acked data is dropped. The next request uses the target.
  - In S_HELD or S_IDLE: go to S_WAIT requesting the target next cycle.
- branch_taken in consecutive cycles: the last target wins; discard stays set until the single outstanding ack returns.
- PC arithmetic: pc+4 truncated to PC_WIDTH; 0xFFFFFFFC+4 wraps to 0.
- Only one outstanding request at any time.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32) and perf_stall_cycles (32).
  - perf_fetched increments on each IF/ID load with valid=1.
  - perf_stall_cycles increments on each cycle with stall=1 and if_id_valid=1.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and counters do not exist; no other behaviour change.

Test Plan:
- Reset, then ack every cycle with rdata = 0x8C220004, 0x00432020, 0x1000FFFE -> instr_op = 0x23, 0x00, 0x04 on consecutive cycles; if_id_pc_plus4 = 4, 8, 12; imem_addr = 0, 4, 8, 12.
- Ack delayed 3 cycles -> imem_addr held at 0 and imem_req=1 for 4 cycles; IF/ID loads only on the ack cycle.
- stall=1 for 2 cycles while an ack arrives -> IF/ID unchanged, imem_req=0 in S_HELD. When stall releases, the skid word appears next cycle and no fetch is lost or duplicated.
- branch_taken with target 0x103 while a request to 0x8 is outstanding -> 0x8 ack data dropped; next imem_addr=0x100; if_id_valid=0 until the 0x100 ack.
- RESET_PC=32'hFFFFFFFC -> first fetch at 0xFFFFFFFC, second at 0x0; if_id_pc_plus4=0.
- rst asserted mid-S_WAIT with ack in the same cycle -> all outputs return to reset values and the ack data is not loaded.
